// File: rtl/regfile_sb.sv
// Multi-port register file with same-cycle writeback bypass and a busy-bit
// scoreboard for long-latency destinations; the PC slot is served from PC_IN.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int AW     = 4,
  parameter int NRD    = 3,
  parameter int PC_IDX = 15
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic [NRD*AW-1:0]     RA,
  output logic [NRD*DATA_W-1:0] RD,
  output logic [NRD-1:0]        RD_BUSY,
  input  logic [DATA_W-1:0]     PC_IN,
  input  logic                  WE0,
  input  logic [AW-1:0]         WA0,
  input  logic [DATA_W-1:0]     WD0,
  input  logic                  WE1,
  input  logic [AW-1:0]         WA1,
  input  logic [DATA_W-1:0]     WD1,
  input  logic                  ISS_EN,
  input  logic [AW-1:0]         ISS_RD,
  output logic [NREG-1:0]       BUSY,
  output logic                  ERR
);

  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < NREG;
  endfunction

  function automatic logic real_reg(input logic [AW-1:0] a);
    return in_range(a) && (a != PC_A);
  endfunction

  function automatic logic busy_at(input logic [NREG-1:0] v, input logic [AW-1:0] a);
    logic b;
    b = 1'b0;
    for (int r = 0; r < NREG; r++)
      if (int'(a) == r) b = v[r];
    return b;
  endfunction

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy_q;
  logic              err_q;
  logic              err_set;

  // Protocol checks use the registered busy vector; a completion landing on the
  // same register in this cycle frees it for a fresh issue.
  always_comb begin
    err_set = 1'b0;
    if (WE0 && !in_range(WA0)) err_set = 1'b1;
    if (WE1 && !in_range(WA1)) err_set = 1'b1;
    if (WE0 && WE1 && (WA0 == WA1) && real_reg(WA0)) err_set = 1'b1;
    if (ISS_EN && !real_reg(ISS_RD)) err_set = 1'b1;
    if (ISS_EN && real_reg(ISS_RD) && busy_at(busy_q, ISS_RD) &&
        !(WE1 && (WA1 == ISS_RD))) err_set = 1'b1;
    if (WE1 && real_reg(WA1) && !busy_at(busy_q, WA1)) err_set = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r != PC_IDX) begin
          if (WE0 && (int'(WA0) == r))      regs[r] <= WD0;
          else if (WE1 && (int'(WA1) == r)) regs[r] <= WD1;
          // A younger issue outranks the completion of the older op
          if (ISS_EN && (int'(ISS_RD) == r))  busy_q[r] <= 1'b1;
          else if (WE1 && (int'(WA1) == r))   busy_q[r] <= 1'b0;
        end
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rd;
    assign ra = RA[k*AW +: AW];
    always_comb begin
      rd = '0;
      if (ra == PC_A)                rd = PC_IN;
      else if (!in_range(ra))        rd = '0;
      else if (WE0 && (WA0 == ra))   rd = WD0;
      else if (WE1 && (WA1 == ra))   rd = WD1;
      else
        for (int r = 0; r < NREG; r++)
          if (int'(ra) == r) rd = regs[r];
    end
    assign RD[k*DATA_W +: DATA_W] = rd;
    assign RD_BUSY[k] = busy_at(busy_q, ra);
  end

  assign BUSY = busy_q;
  assign ERR  = err_q;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port register file with an integrated scoreboard for the pipelined core. It provides NRD combinational read ports and two writeback ports: WP0 for single-cycle ALU/load results, WP1 for long-latency units (multiplier, float). Same-cycle writeback data is bypassed to readers. A per-register busy bit tracks destinations of in-flight long-latency operations so issue logic can stall on hazards. The PC index is served from an external input instead of storage.

## Interface
- DATA_W, 32, register width in bits
- NREG, 16, number of architectural registers including the PC slot
- AW, 4, address width; must satisfy 2**AW >= NREG
- NRD, 3, number of read ports
- PC_IDX, 15, index whose reads return PC_IN and whose writes and issues are ignored

- CLK  in  1  clock; all state updates on the rising edge
- RESETn  in  1  asynchronous active-low reset
- RA  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
- RD  out  NRD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
- RD_BUSY  out  NRD  port k reads a register whose busy bit is set
- PC_IN  in  DATA_W  value returned for reads of PC_IDX
- WE0  in  1  WP0 write enable
- WA0  in  AW  WP0 address
- WD0  in  DATA_W  WP0 data
- WE1  in  1  WP1 write enable (long-latency completion)
- WA1  in  AW  WP1 address
- WD1  in  DATA_W  WP1 data
- ISS_EN  in  1  long-latency op issued this cycle
- ISS_RD  in  AW  destination of the issued op
- BUSY  out  NREG  busy bit vector
- ERR  out  1  sticky collision/protocol error flag

## Operation
- Storage holds NREG-1 registers; the PC_IDX slot has no storage.
- Read port k is combinational, with priority from highest to lowest:
  - RA_k == PC_IDX -> PC_IN
  - WE0 && WA0 == RA_k -> WD0
  - WE1 && WA1 == RA_k -> WD1
  - otherwise the stored value
- Addresses >= NREG read 0. Writes to them are dropped and set ERR.
- Write: on the rising edge, WP0 and WP1 update their targets. Writes to PC_IDX are dropped silently.
- Write collision (WE0 && WE1 && WA0 == WA1, not PC_IDX):
  - WD0 is stored.
  - ERR is set.
  - The busy bit still clears, because WP1 completed.
- Scoreboard:
  - WE1 to register r clears BUSY[r].
  - ISS_EN sets BUSY[ISS_RD].
  - Set and clear on the same register in the same cycle -> set wins (new issue is younger).
  - ISS_EN to PC_IDX or an out-of-range index is ignored and sets ERR.
  - ISS_EN to a register already busy sets ERR. This is a WAW hazard that the issue stage must stall; BUSY stays 1.
  - WE1 to a non-busy register sets ERR. The write still occurs.
  - WE0 does not affect BUSY.
- RD_BUSY[k] = BUSY[RA_k] from the registered vector, before this cycle's clear. 0 for PC_IDX and out-of-range addresses.
- ERR is sticky until reset.

## Timing
- Reset (RESETn low, asynchronous): all registers = 0, BUSY = 0, ERR = 0. RD then reflects 0 (or PC_IN for PC_IDX) combinationally.
- Deassertion is expected to be synchronised externally; the block assumes release away from the CLK edge.
- Read latency: 0 cycles, combinational from RA/WE/WA/WD/PC_IN.
- Write latency: data is visible via bypass in the same cycle and from storage from the next cycle.
- BUSY/RD_BUSY:
  - A set from ISS_EN is visible from cycle N+1.
  - A clear from WE1 is visible from cycle N+1.
  - Readers in cycle N still get correct data via the WP1 bypass.
- Reset asserted mid-operation discards all pending busy bits. Completions arriving after reset then set ERR only if they arrive with WE1 to a non-busy register.

## Test plan
- Reset: drive RESETn=0 mid-cycle -> RD all 0, BUSY=0, ERR=0 immediately, without a clock edge.
- Basic write/read: WE0, WA0=3, WD0=0xDEADBEEF -> RA0=3 reads 0xDEADBEEF the same cycle (bypass) and the next cycle (storage); RA1=15 with PC_IN=0x100 reads 0x100.
- Scoreboard: ISS_EN, ISS_RD=5 at cycle 1 -> BUSY[5]=1 and RD_BUSY for RA=5 from cycle 2. At cycle 4, WE1 WA1=5 WD1=0x1234 -> RD=0x1234 in cycle 4, BUSY[5]=0 from cycle 5, ERR=0.
- Simultaneous issue and completion on r7 (BUSY[7]=1, WE1 WA1=7, ISS_EN ISS_RD=7) -> r7 written, BUSY[7] stays 1, ERR=0.
- Collision: WE0 WA0=2 WD0=0xA, WE1 WA1=2 WD1=0xB with BUSY[2]=1 -> r2=0xA, BUSY[2]=0, ERR=1 and stays 1.
- Protocol errors: ISS_EN to a busy r4 -> ERR=1; WE0 to PC_IDX -> storage unchanged, reads still return PC_IN.
